byte_lane_sequencer: RTL and testbench

Parametrised successor to the console's 16-to-8 data bus multiplexer. Splits each wide CPU memory cycle into `LANES` sequential narrow accesses, with a configurable wait-state count, selectable lane order, `sysrdy` stretching and abort on `memen` drop. Sits between the CPU bus (`q`, `d`, `ready`) and the narrow peripheral bus (GROM, cartridge ROM, PEB side: `d8`, `q8`, `memen8`, `a15`). It replaces the fixed two-byte multiplexer in the mainboard.

---
 rtl/mux_pkg.sv | 28 ++
 rtl/byte_lane_sequencer.sv | 111 +++++++++++
 tb/tb_byte_lane_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mux_pkg: shared state type and lane-order helpers for the sequencer|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Lane index width; a single lane still needs one bit to carry a15.
  function automatic int lane_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  function automatic int lane_first(input int lanes, input int low_first);
    return (low_first != 0) ? lanes - 1 : 0;
  endfunction

  function automatic int lane_last(input int lanes, input int low_first);
    return (low_first != 0) ? 0 : lanes - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_lane_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | byte_lane_sequencer: splits a wide CPU cycle into narrow lane      |
// | accesses with wait states, sysrdy stretching and memen abort.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module byte_lane_sequencer
  import mux_pkg::*;
#(
  parameter int WIDE_WIDTH   = 16,
  parameter int NARROW_WIDTH = 8,
  parameter int WAIT_STATES  = 4,
  parameter int LOW_FIRST    = 1,
  localparam int LANES  = WIDE_WIDTH / NARROW_WIDTH,
  localparam int LANE_W = lane_width(LANES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic                    start,
  input  logic                    memen,
  input  logic                    dbin,
  input  logic                    sysrdy,
  output logic                    ready,
  output logic                    memen8,
  output logic [0:LANE_W-1]       lane,
  output logic                    a15,
  input  logic [0:NARROW_WIDTH-1] d8,
  output logic [0:NARROW_WIDTH-1] q8,
  input  logic [0:WIDE_WIDTH-1]   q,
  output logic [0:WIDE_WIDTH-1]   d
);

  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [LANE_W-1:0] FIRST_LANE = LANE_W'(lane_first(LANES, LOW_FIRST));
  localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(lane_last(LANES, LOW_FIRST));
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(WAIT_STATES);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [LANE_W-1:0]      r_lane;
  logic [0:WIDE_WIDTH-1]  r_d;
  logic [LANE_W-1:0]      w_next_lane;

  assign w_next_lane = (LOW_FIRST != 0) ? (r_lane - LANE_W'(1)) : (r_lane + LANE_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_lane  <= '0;
      r_cnt   <= '0;
      r_d     <= '1;
    end else if (clk_en) begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= ACCESS;
            r_lane  <= FIRST_LANE;
            r_cnt   <= CNT_RELOAD;
            r_d     <= '1;
          end
        end
        ACCESS: begin
          if (!memen) begin
            r_state <= IDLE;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (sysrdy) begin
            // Lane 0 lands in the most significant field of the word.
            if (dbin) begin
              for (int i = 0; i < LANES; i++) begin
                if (r_lane == LANE_W'(i)) begin
                  r_d[i*NARROW_WIDTH +: NARROW_WIDTH] <= d8;
                end
              end
            end
            if (r_lane == LAST_LANE) begin
              r_state <= DONE;
            end else begin
              r_lane <= w_next_lane;
              r_cnt  <= CNT_RELOAD;
            end
          end
        end
        DONE: begin
          if (!memen) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    q8 = q[0 +: NARROW_WIDTH];
    for (int i = 0; i < LANES; i++) begin
      if (r_lane == LANE_W'(i)) begin
        q8 = q[i*NARROW_WIDTH +: NARROW_WIDTH];
      end
    end
  end

  assign ready  = ((r_state == IDLE) && !start) || (r_state == DONE);
  assign memen8 = (r_state == ACCESS);
  assign lane   = r_lane;
  assign a15    = r_lane[0];
  assign d      = r_d;

endmodule
`default_nettype wire

// File: tb/tb_byte_lane_sequencer.sv
`default_nettype none
// Self-checking bench for byte_lane_sequencer: vector table, hand-written corner
// sequences and randomized transactions checked against a transaction-level model.
module tb_byte_lane_sequencer;

  localparam int WS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, clk_en;

  logic        start, memen, dbin, sysrdy;
  logic        ready, memen8, a15;
  logic [0:0]  lane;
  logic [0:7]  d8, q8;
  logic [0:15] q, d;

  logic        start32, memen32, dbin32, sysrdy32;
  logic        ready32, memen8_32, a15_32;
  logic [0:1]  lane32;
  logic [0:7]  d8_32, q8_32;
  logic [0:31] q32, d32;

  int checks = 0;
  int errors = 0;

  byte_lane_sequencer dut16 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .memen(memen),
    .dbin(dbin), .sysrdy(sysrdy), .ready(ready), .memen8(memen8), .lane(lane),
    .a15(a15), .d8(d8), .q8(q8), .q(q), .d(d)
  );

  byte_lane_sequencer #(
    .WIDE_WIDTH(32), .NARROW_WIDTH(8), .WAIT_STATES(0), .LOW_FIRST(0)
  ) dut32 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start32), .memen(memen32),
    .dbin(dbin32), .sysrdy(sysrdy32), .ready(ready32), .memen8(memen8_32), .lane(lane32),
    .a15(a15_32), .d8(d8_32), .q8(q8_32), .q(q32), .d(d32)
  );

  typedef struct {
    logic        rd;
    logic [15:0] qv;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          st0;
    int          st1;
    logic [15:0] exp_d;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full 16-bit transaction. The lane schedule follows the rules directly:
  // each lane is WS ignored-sysrdy ticks, then st stall ticks, then one completing tick.
  task automatic run16(input logic rd, input logic [15:0] qv, input logic [7:0] b0,
                       input logic [7:0] b1, input int st0, input int st1,
                       input bit gaps, input logic [15:0] exp_d);
    int         order[2];
    int         stall[2];
    logic [7:0] bytes[2];
    order[0] = 1; order[1] = 0;
    stall[0] = st0; stall[1] = st1;
    bytes[0] = b0; bytes[1] = b1;
    clk_en = 1'b1; dbin = rd; q = qv; memen = 1'b1; sysrdy = 1'b0; start = 1'b1;
    #1;
    chk("ready_drops_with_start", {31'd0, ready}, 32'd0);
    step();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      int L;
      int n;
      L = order[k];
      n = WS + stall[L] + 1;
      for (int t = 0; t < n; t++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          clk_en = 1'b0; sysrdy = 1'b1; d8 = 8'hEE;
          step();
          chk("freeze_a15", {31'd0, a15}, L);
          chk("freeze_memen8", {31'd0, memen8}, 32'd1);
          clk_en = 1'b1;
        end
        d8 = bytes[L];
        sysrdy = (t < WS) ? 1'($urandom_range(0, 1)) : 1'(t == n - 1);
        #1;
        chk("memen8_active", {31'd0, memen8}, 32'd1);
        chk("a15_lane", {31'd0, a15}, L);
        chk("q8_slice", {24'd0, q8}, (32'(qv) >> (8 * (1 - L))) & 32'hFF);
        chk("ready_busy", {31'd0, ready}, 32'd0);
        step();
      end
    end
    chk("ready_done", {31'd0, ready}, 32'd1);
    chk("memen8_done", {31'd0, memen8}, 32'd0);
    chk("d_word", {16'd0, d}, {16'd0, exp_d});
    start = 1'b1;
    step();
    chk("done_ignores_start", {31'd0, memen8}, 32'd0);
    chk("done_d_stable", {16'd0, d}, {16'd0, exp_d});
    start = 1'b0; memen = 1'b0;
    step();
    chk("idle_ready", {31'd0, ready}, 32'd1);
    chk("idle_memen8", {31'd0, memen8}, 32'd0);
  endtask

  task automatic run32(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3, input logic [31:0] qv);
    logic [7:0] bytes[4];
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    clk_en = 1'b1; dbin32 = 1'b1; memen32 = 1'b1; sysrdy32 = 1'b1; q32 = qv; start32 = 1'b1;
    step();
    start32 = 1'b0;
    for (int l = 0; l < 4; l++) begin
      d8_32 = bytes[l];
      #1;
      chk("lane32_order", {30'd0, lane32}, l);
      chk("a15_32", {31'd0, a15_32}, l & 1);
      chk("q8_32_slice", {24'd0, q8_32}, (qv >> (8 * (3 - l))) & 32'hFF);
      step();
    end
    chk("ready32_done", {31'd0, ready32}, 32'd1);
    chk("d32_word", d32, {b0, b1, b2, b3});
    memen32 = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b0;
    start = 1'b0; memen = 1'b0; dbin = 1'b0; sysrdy = 1'b0; d8 = '0; q = '0;
    start32 = 1'b0; memen32 = 1'b0; dbin32 = 1'b0; sysrdy32 = 1'b0; d8_32 = '0; q32 = '0;

    #13;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_memen8", {31'd0, memen8}, 32'd0);
    chk("rst_a15", {31'd0, a15}, 32'd0);
    chk("rst_lane", {31'd0, lane}, 32'd0);
    chk("rst_d", {16'd0, d}, 32'h0000FFFF);
    #10 reset = 1'b0;
    step();

    vecs[0] = '{1'b1, 16'h0000, 8'h12, 8'h34, 0, 0, 16'h1234};
    vecs[1] = '{1'b0, 16'hABCD, 8'h55, 8'h66, 0, 0, 16'hFFFF};
    vecs[2] = '{1'b1, 16'h5A5A, 8'h12, 8'h34, 0, 3, 16'h1234};
    vecs[3] = '{1'b1, 16'hC3C3, 8'hFF, 8'h00, 2, 1, 16'hFF00};
    vecs[4] = '{1'b0, 16'h0F0F, 8'h12, 8'h34, 1, 2, 16'hFFFF};
    for (int i = 0; i < 5; i++) begin
      run16(vecs[i].rd, vecs[i].qv, vecs[i].b0, vecs[i].b1,
            vecs[i].st0, vecs[i].st1, 1'b0, vecs[i].exp_d);
    end

    // Abort part-way through lane 0: partial word must be kept.
    dbin = 1'b1; memen = 1'b1; start = 1'b1; clk_en = 1'b1; sysrdy = 1'b1; d8 = 8'h56;
    step();
    start = 1'b0;
    repeat (WS + 1) step();
    d8 = 8'h99;
    step(); step();
    chk("abort_in_lane0", {31'd0, a15}, 32'd0);
    memen = 1'b0;
    step();
    chk("abort_memen8", {31'd0, memen8}, 32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_partial_d", {16'd0, d}, 32'h0000FF56);
    #2 reset = 1'b1;
    #1 chk("async_rst_d", {16'd0, d}, 32'h0000FFFF);
    #2 reset = 1'b0;
    step();
    run16(1'b1, 16'h0000, 8'hBE, 8'hEF, 0, 0, 1'b0, 16'hBEEF);

    // Asynchronous reset between edges in the middle of lane 1.
    dbin = 1'b1; memen = 1'b1; start = 1'b1; sysrdy = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("pre_rst_a15", {31'd0, a15}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_memen8", {31'd0, memen8}, 32'd0);
    chk("mid_rst_a15", {31'd0, a15}, 32'd0);
    chk("mid_rst_d", {16'd0, d}, 32'h0000FFFF);
    chk("mid_rst_ready", {31'd0, ready}, 32'd1);
    #2 reset = 1'b0; memen = 1'b0;
    step();

    for (int i = 0; i < 25; i++) begin
      logic        rd;
      logic [15:0] qv;
      logic [7:0]  b0, b1;
      rd = 1'($urandom_range(0, 1));
      qv = 16'($urandom);
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      run16(rd, qv, b0, b1, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1,
            rd ? {b0, b1} : 16'hFFFF);
    end

    run32(8'h11, 8'h22, 8'h33, 8'h44, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      run32(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
